lcd_fb_arbiter: RTL and testbench
=================================

Name: lcd_fb_arbiter

Overview:
- Arbitrates one single-port video SRAM (frame buffer) between two requesters:
  - the display refresh path, which issues pixel reads driven by the LCD timing generator's Column/Row outputs;
  - the graphics/CPU port, which issues single-word reads and writes.
- Display has strict priority. The graphics port gets only the slots the display leaves free.
- Sits between the timing generator/pixel-fetch logic and the SRAM pins, and sequences all memory commands including the bus turnaround.

Parameters:
- ADDR_W, 19, word address width (800x480 = 384000 words < 2^19).
- DATA_W, 16, pixel word width (RGB565).
- RD_LAT, 2, SRAM read latency in cycles from command on bus to Mem_RdData valid; legal range 1..4.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-low.
- Blank_L  in  1  video blanking from timing generator; low = no active video.
- Disp_Req  in  1  display read request (level).
- Disp_Addr  in  ADDR_W  display read address.
- Disp_Grant  out  1  1-cycle pulse: display read issued this cycle.
- Disp_RdValid  out  1  1-cycle pulse: Disp_RdData valid.
- Disp_RdData  out  DATA_W  display read data.
- Gfx_Req  in  1  graphics request; Addr/WE/WrData held stable until Gfx_Ack.
- Gfx_WE  in  1  1 = write, 0 = read.
- Gfx_Addr  in  ADDR_W  graphics address.
- Gfx_WrData  in  DATA_W  graphics write data.
- Gfx_Ack  out  1  1-cycle pulse: write issued, or read data valid.
- Gfx_RdData  out  DATA_W  graphics read data, valid with Gfx_Ack on reads.
- Mem_CS_L, Mem_OE_L, Mem_WE_L  out  1 each  SRAM strobes, active-low.
- Mem_Addr  out  ADDR_W  SRAM address.
- Mem_WrData  out  DATA_W  SRAM write data.
- Mem_RdData  in  DATA_W  SRAM read data.

Behaviour:
- All outputs are registered. A decision made in cycle N appears on Mem_*, Disp_Grant and Gfx_Ack (writes) in cycle N+1, called the command cycle T.
- Reset (Reset==0 at a clock edge):
  - Mem_CS_L = Mem_OE_L = Mem_WE_L = 1.
  - Mem_Addr, Mem_WrData, Disp_RdData, Gfx_RdData = 0.
  - Disp_Grant, Disp_RdValid, Gfx_Ack = 0.
  - Tag pipeline cleared, gfx_busy = 0, state = IDLE.
  - Reset mid-operation discards in-flight reads: no RdValid or Ack is ever produced for them.
- States, with the bus during each:
  - IDLE: no command, strobes high.
  - RD: CS_L = 0, OE_L = 0.
  - WR: CS_L = 0, WE_L = 0, Mem_WrData driven.
  - TURN: no command, strobes high.
- Next-state priority, evaluated every cycle:
  1. Current state WR: go to TURN unconditionally. No read is issued in the cycle after a write.
  2. Disp_Req == 1: go to RD with the display address. Disp_Grant = 1 and tag DISP is pushed. Back-to-back display reads are allowed every cycle.
  3. Gfx_Req == 1, Gfx_WE == 0, gfx_busy == 0: go to RD with the gfx address, push tag GFX, set gfx_busy.
  4. Gfx_Req == 1, Gfx_WE == 1, tag pipeline fully empty: go to WR. Gfx_Ack = 1 in cycle T.
  5. Otherwise: go to IDLE.
- Tag pipeline: RD_LAT+1 stages holding NONE/DISP/GFX. Mem_RdData is sampled at T+RD_LAT.
  - DISP tag: Disp_RdValid = 1 and Disp_RdData = sample in cycle T+RD_LAT+1.
  - GFX tag: Gfx_Ack = 1 and Gfx_RdData = sample in cycle T+RD_LAT+1; gfx_busy clears that cycle.
- Simultaneous Disp_Req and Gfx_Req: display wins. Gfx_Req stays pending with no starvation guard, since display has absolute priority.
- Gfx_Req must not be dropped before Gfx_Ack. Gfx_Req is ignored while gfx_busy == 1.
- An issued gfx request is never re-issued. The requester deasserts Gfx_Req in the cycle after Gfx_Ack.
- Blank_L has no effect unless the optional feature is enabled.

Optional Feature:
- Macro: LCD_FB_BLANK_ONLY_WRITE_EN.
- Defined: priority rule 4 additionally requires Blank_L == 0, so gfx writes occur only during blanking (tear-free updates). Gfx reads are unrestricted.
- Undefined: Blank_L is unused and gfx writes proceed whenever rule 4 allows.

Decomposition:
- Shared package lcd_fb_pkg:
  - state enum {IDLE, RD, WR, TURN};
  - tag enum {TAG_NONE, TAG_DISP, TAG_GFX};
  - default ADDR_W/DATA_W constants and LCD_H_RES = 800, LCD_V_RES = 480.
- Sub-module lcd_fb_rd_tag_pipe: parameterised RD_LAT+1 tag shift register with synchronous clear and an empty flag.

Test Plan:
- Reset: hold Reset = 0 for 3 cycles with Disp_Req = 1 -> all Mem strobes 1, no Grant, RdValid or Ack. Release -> first RD appears 1 cycle later.
- Display streaming: Disp_Req = 1 for 8 cycles, Disp_Addr = 0..7, RD_LAT = 2, SRAM model returns addr+0x100 -> Disp_Grant high 8 consecutive cycles; Disp_RdValid 3 cycles after each grant with data 0x100..0x107 in order.
- Contention: Disp_Req and Gfx_Req (read, addr 0x1234) asserted together for 4 cycles, then Disp_Req = 0 -> gfx read issued on the 5th command slot; Gfx_Ack with mem[0x1234] RD_LAT+1 cycles later.
- Write hazard: display read at addr 5, then Gfx write addr 9 = 0xBEEF -> WR waits until tag pipe empty; WR on bus, then TURN (no command); readback of addr 9 returns 0xBEEF.
- Reset mid-read: pulse Reset low 1 cycle after a display grant -> no Disp_RdValid for that read; strobes high.
- With LCD_FB_BLANK_ONLY_WRITE_EN: gfx write while Blank_L = 1 -> no WR, no Ack. Drive Blank_L = 0 -> WR next cycle, Gfx_Ack = 1.

Source files
------------

// File: rtl/lcd_fb_pkg.sv
// Shared types and constants for the LCD frame-buffer arbiter.
package lcd_fb_pkg;
  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;
  localparam int LCD_H_RES  = 800;
  localparam int LCD_V_RES  = 480;

  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_GFX} tag_e;
endpackage

// File: rtl/lcd_fb_arbiter_if.sv
// Requester and SRAM-pin bundle of the frame-buffer arbiter.
// slave = arbiter view, master = the surrounding logic / SRAM.
interface lcd_fb_arbiter_if #(
  parameter int ADDR_W = lcd_fb_pkg::ADDR_W_DEF,
  parameter int DATA_W = lcd_fb_pkg::DATA_W_DEF
);
  logic              Blank_L;
  logic              Disp_Req;
  logic [ADDR_W-1:0] Disp_Addr;
  logic              Disp_Grant;
  logic              Disp_RdValid;
  logic [DATA_W-1:0] Disp_RdData;
  logic              Gfx_Req;
  logic              Gfx_WE;
  logic [ADDR_W-1:0] Gfx_Addr;
  logic [DATA_W-1:0] Gfx_WrData;
  logic              Gfx_Ack;
  logic [DATA_W-1:0] Gfx_RdData;
  logic              Mem_CS_L;
  logic              Mem_OE_L;
  logic              Mem_WE_L;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WrData;
  logic [DATA_W-1:0] Mem_RdData;

  modport slave (
    input  Blank_L, Disp_Req, Disp_Addr, Gfx_Req, Gfx_WE, Gfx_Addr, Gfx_WrData, Mem_RdData,
    output Disp_Grant, Disp_RdValid, Disp_RdData, Gfx_Ack, Gfx_RdData,
           Mem_CS_L, Mem_OE_L, Mem_WE_L, Mem_Addr, Mem_WrData
  );

  modport master (
    output Blank_L, Disp_Req, Disp_Addr, Gfx_Req, Gfx_WE, Gfx_Addr, Gfx_WrData, Mem_RdData,
    input  Disp_Grant, Disp_RdValid, Disp_RdData, Gfx_Ack, Gfx_RdData,
           Mem_CS_L, Mem_OE_L, Mem_WE_L, Mem_Addr, Mem_WrData
  );
endinterface

// File: rtl/lcd_fb_rd_tag_pipe.sv
// Read-tag shift register: one stage per cycle of SRAM read latency plus the
// command cycle. The last stage names the owner of the data on Mem_RdData.
module lcd_fb_rd_tag_pipe
  import lcd_fb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic Clock,
  input  logic Reset,
  input  tag_e push_tag,
  output tag_e tail_tag,
  output logic empty
);
  tag_e stage [DEPTH];

  // shift tags toward the tail; reset drops every in-flight read
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // empty when no stage holds a read
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (stage[i] != TAG_NONE) empty = 1'b0;
  end

  assign tail_tag = stage[DEPTH-1];
endmodule

// File: rtl/lcd_fb_arbiter.sv
// Single-port frame-buffer SRAM arbiter: display reads have absolute
// priority, graphics/CPU port gets the leftover slots. Every write is
// followed by a turnaround cycle, and writes wait for all reads to drain.
// Optional: define LCD_FB_BLANK_ONLY_WRITE_EN to allow graphics writes only
// while Blank_L is low (tear-free updates).
// RD_LAT legal range is 1..4.
module lcd_fb_arbiter
  import lcd_fb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 2
) (
  input logic              Clock,
  input logic              Reset,
  lcd_fb_arbiter_if.slave  bus
);
  state_e            state, state_nxt;
  tag_e              push_tag, tail_tag;
  logic              tag_empty;
  logic              wr_ok;
  logic              gfx_busy;
  logic              gfx_rd_ack;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] rd_sample;

  assign rd_sample = bus.Mem_RdData;

  lcd_fb_rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tags (
    .Clock    (Clock),
    .Reset    (Reset),
    .push_tag (push_tag),
    .tail_tag (tail_tag),
    .empty    (tag_empty)
  );

`ifdef LCD_FB_BLANK_ONLY_WRITE_EN
  assign wr_ok = tag_empty && !bus.Blank_L;
`else
  logic unused_blank;
  assign unused_blank = bus.Blank_L;
  assign wr_ok = tag_empty;
`endif

  // next-command decision: turnaround, display, gfx read, gfx write, idle
  always_comb begin
    state_nxt = IDLE;
    push_tag  = TAG_NONE;
    nxt_addr  = '0;
    if (state == WR) begin
      state_nxt = TURN;
    end else if (bus.Disp_Req) begin
      state_nxt = RD;
      push_tag  = TAG_DISP;
      nxt_addr  = bus.Disp_Addr;
    end else if (bus.Gfx_Req && !bus.Gfx_WE && !gfx_busy) begin
      state_nxt = RD;
      push_tag  = TAG_GFX;
      nxt_addr  = bus.Gfx_Addr;
    end else if (bus.Gfx_Req && bus.Gfx_WE && wr_ok) begin
      state_nxt = WR;
      nxt_addr  = bus.Gfx_Addr;
    end
  end

  // registered bus strobes, grants and read returns
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state            <= IDLE;
      gfx_busy         <= 1'b0;
      gfx_rd_ack       <= 1'b0;
      bus.Mem_CS_L     <= 1'b1;
      bus.Mem_OE_L     <= 1'b1;
      bus.Mem_WE_L     <= 1'b1;
      bus.Mem_Addr     <= '0;
      bus.Mem_WrData   <= '0;
      bus.Disp_Grant   <= 1'b0;
      bus.Disp_RdValid <= 1'b0;
      bus.Disp_RdData  <= '0;
      bus.Gfx_Ack      <= 1'b0;
      bus.Gfx_RdData   <= '0;
    end else begin
      state        <= state_nxt;
      bus.Mem_CS_L <= !(state_nxt == RD || state_nxt == WR);
      bus.Mem_OE_L <= (state_nxt != RD);
      bus.Mem_WE_L <= (state_nxt != WR);
      if (state_nxt == RD || state_nxt == WR) bus.Mem_Addr <= nxt_addr;
      if (state_nxt == WR) bus.Mem_WrData <= bus.Gfx_WrData;
      bus.Disp_Grant   <= (push_tag == TAG_DISP);
      bus.Disp_RdValid <= (tail_tag == TAG_DISP);
      if (tail_tag == TAG_DISP) bus.Disp_RdData <= rd_sample;
      bus.Gfx_Ack <= (state_nxt == WR) || (tail_tag == TAG_GFX);
      if (tail_tag == TAG_GFX) bus.Gfx_RdData <= rd_sample;
      gfx_rd_ack <= (tail_tag == TAG_GFX);
      // busy stays up through the ack cycle, where Gfx_Req is still held,
      // so the finished read is never re-issued
      if (push_tag == TAG_GFX) gfx_busy <= 1'b1;
      else if (gfx_rd_ack)     gfx_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Bench for lcd_fb_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a slot-level reference model.
module tb_lcd_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int B_IDLE = 0, B_RD = 1, B_WR = 2;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  lcd_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  lcd_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic          rst_n, blank_l, dreq;
    logic [AW-1:0] daddr;
    logic          greq, gwe;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gwd;
  } in_t;

  typedef struct {
    in_t           iv;
    logic          cs, oe, we, grant, rdv, ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  typedef struct {
    bit            rst, cs, oe, we, grant, rdv, ack, gack_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, ddata, gdata;
  } exp_t;

  typedef struct {
    int            t;
    bit            gfx;
    logic [DW-1:0] d;
  } rd_t;

  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a + 'h100);
  endfunction

  // ---------------- SRAM responder (environment) ----------------
  logic [DW-1:0] smem [int];
  logic [DW-1:0] sline [RL+1];
  always @(negedge Clock) begin
    int a;
    for (int k = RL; k > 0; k--) sline[k] = sline[k-1];
    sline[0] = DW'($urandom);
    if (bus.Mem_CS_L === 1'b0) begin
      a = int'(bus.Mem_Addr);
      if (bus.Mem_OE_L === 1'b0) sline[0] = smem.exists(a) ? smem[a] : init_word(a);
      if (bus.Mem_WE_L === 1'b0) smem[a] = bus.Mem_WrData;
    end
    bus.Mem_RdData = sline[RL];
  end

  // ---------------- reference model (slot level) ----------------
  logic [DW-1:0] mmem [int];
  rd_t  q[$];
  exp_t e;
  int   cyc = 0;
  bit   prev_wr = 0;
  int   last_rd = -100;
  int   gfx_until = -100;

  function automatic logic [DW-1:0] mread(input int a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  // predicts the outputs of the next cycle from this cycle's inputs
  task automatic model_decide(input in_t iv);
    rd_t r;
    bit  wr_ok;
    e = '{default: '0};
    e.cs = 1; e.oe = 1; e.we = 1;
    if (!iv.rst_n) begin
      e.rst = 1;
      q.delete();
      prev_wr = 0; last_rd = -100; gfx_until = -100;
    end else begin
      if (q.size() > 0 && q[0].t + RL + 1 == cyc + 1) begin
        r = q.pop_front();
        if (r.gfx) begin e.ack = 1; e.gack_rd = 1; e.gdata = r.d; end
        else begin e.rdv = 1; e.ddata = r.d; end
      end
      wr_ok = (cyc > last_rd + RL);
`ifdef LCD_FB_BLANK_ONLY_WRITE_EN
      wr_ok = wr_ok && !iv.blank_l;
`endif
      if (prev_wr) begin
        prev_wr = 0;
      end else if (iv.dreq) begin
        e.cs = 0; e.oe = 0; e.grant = 1; e.addr = iv.daddr;
        q.push_back('{cyc + 1, 1'b0, mread(int'(iv.daddr))});
        last_rd = cyc + 1;
      end else if (iv.greq && !iv.gwe && cyc > gfx_until) begin
        e.cs = 0; e.oe = 0; e.addr = iv.gaddr;
        q.push_back('{cyc + 1, 1'b1, mread(int'(iv.gaddr))});
        last_rd = cyc + 1;
        gfx_until = cyc + 2 + RL;
      end else if (iv.greq && iv.gwe && wr_ok) begin
        e.cs = 0; e.we = 0; e.ack = 1; e.addr = iv.gaddr; e.wdata = iv.gwd;
        mmem[int'(iv.gaddr)] = iv.gwd;
        prev_wr = 1;
      end
    end
  endtask

  task automatic model_check();
    bit ok;
    ok = (bus.Mem_CS_L === e.cs) && (bus.Mem_OE_L === e.oe) && (bus.Mem_WE_L === e.we) &&
         (bus.Disp_Grant === e.grant) && (bus.Disp_RdValid === e.rdv) && (bus.Gfx_Ack === e.ack);
    if (e.rst) ok = ok && (bus.Mem_Addr === '0) && (bus.Mem_WrData === '0) &&
                    (bus.Disp_RdData === '0) && (bus.Gfx_RdData === '0);
    if (!e.cs)     ok = ok && (bus.Mem_Addr === e.addr);
    if (!e.we)     ok = ok && (bus.Mem_WrData === e.wdata);
    if (e.rdv)     ok = ok && (bus.Disp_RdData === e.ddata);
    if (e.gack_rd) ok = ok && (bus.Gfx_RdData === e.gdata);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model cyc=%0d got cs/oe/we=%b%b%b grant=%b rdv=%b ack=%b addr=%h wd=%h dd=%h gd=%h ; want cs/oe/we=%b%b%b grant=%b rdv=%b ack=%b addr=%h wd=%h dd=%h gd=%h",
               cyc, bus.Mem_CS_L, bus.Mem_OE_L, bus.Mem_WE_L, bus.Disp_Grant, bus.Disp_RdValid,
               bus.Gfx_Ack, bus.Mem_Addr, bus.Mem_WrData, bus.Disp_RdData, bus.Gfx_RdData,
               e.cs, e.oe, e.we, e.grant, e.rdv, e.ack, e.addr, e.wdata, e.ddata, e.gdata);
    end
  endtask

  // drive one cycle of inputs, advance, and check the next cycle
  task automatic step(input in_t iv);
    Reset          = iv.rst_n;
    bus.Blank_L    = iv.blank_l;
    bus.Disp_Req   = iv.dreq;
    bus.Disp_Addr  = iv.daddr;
    bus.Gfx_Req    = iv.greq;
    bus.Gfx_WE     = iv.gwe;
    bus.Gfx_Addr   = iv.gaddr;
    bus.Gfx_WrData = iv.gwd;
    model_decide(iv);
    @(negedge Clock);
    cyc++;
    model_check();
  endtask

  function automatic in_t mk_in(input bit r, input bit bl, input bit dq, input int da,
                                input bit gq, input bit gw, input int ga, input int gd);
    in_t iv;
    iv.rst_n = r; iv.blank_l = bl; iv.dreq = dq; iv.daddr = AW'(da);
    iv.greq = gq; iv.gwe = gw; iv.gaddr = AW'(ga); iv.gwd = DW'(gd);
    return iv;
  endfunction

  function automatic vec_t V(input bit r, input bit dq, input int da, input bit gq, input bit gw,
                             input int ga, input int gd, input int bc, input bit gr, input bit rv,
                             input bit ak, input int ea, input int ed);
    vec_t v;
    v.iv = mk_in(r, 1'b0, dq, da, gq, gw, ga, gd);
    v.cs = (bc == B_IDLE); v.oe = (bc != B_RD); v.we = (bc != B_WR);
    v.grant = gr; v.rdv = rv; v.ack = ak;
    v.addr = AW'(ea); v.data = DW'(ed);
    return v;
  endfunction

  task automatic check_bits(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got cs,oe,we,grant,rdv,ack=%b want %b", name, got, want);
    end
  endtask

  function automatic logic [5:0] obs();
    return {bus.Mem_CS_L, bus.Mem_OE_L, bus.Mem_WE_L, bus.Disp_Grant, bus.Disp_RdValid, bus.Gfx_Ack};
  endfunction

  vec_t tbl[$];

  initial begin
    bit ok;
    bit g_act, g_we, g_drop;
    int g_addr, g_wd;
    in_t iv;

    Reset = 1'b0;
    bus.Blank_L = 1'b0; bus.Disp_Req = 1'b1; bus.Disp_Addr = '0;
    bus.Gfx_Req = 1'b0; bus.Gfx_WE = 1'b0; bus.Gfx_Addr = '0; bus.Gfx_WrData = '0;
    @(negedge Clock);

    // ---- directed vector table: inputs this cycle, outputs next cycle ----
    for (int i = 0; i < 3; i++) tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, B_IDLE, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(V(1, 1, k, 0, 0, 0, 0, B_RD, 1, k >= 3, 0, k, 'h100 + k - 3));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, B_IDLE, 0, 1, 0, 0, 'h105));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, B_IDLE, 0, 1, 0, 0, 'h106));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, B_IDLE, 0, 1, 0, 0, 'h107));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, B_IDLE, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(V(1, 1, 'h20, 1, 0, 'h1234, 0, B_RD, 1, k == 3, 0, 'h20, 'h120));
    tbl.push_back(V(1, 0, 0, 1, 0, 'h1234, 0, B_RD, 0, 1, 0, 'h1234, 'h120));
    tbl.push_back(V(1, 0, 0, 1, 0, 'h1234, 0, B_IDLE, 0, 1, 0, 0, 'h120));
    tbl.push_back(V(1, 0, 0, 1, 0, 'h1234, 0, B_IDLE, 0, 1, 0, 0, 'h120));
    tbl.push_back(V(1, 0, 0, 1, 0, 'h1234, 0, B_IDLE, 0, 0, 1, 0, 'h1334));
    tbl.push_back(V(1, 0, 0, 1, 0, 'h1234, 0, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 1, 5, 0, 0, 0, 0, B_RD, 1, 0, 0, 5, 0));
    tbl.push_back(V(1, 0, 0, 1, 1, 9, 'hBEEF, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 1, 1, 9, 'hBEEF, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 1, 1, 9, 'hBEEF, B_IDLE, 0, 1, 0, 0, 'h105));
    tbl.push_back(V(1, 0, 0, 1, 1, 9, 'hBEEF, B_WR, 0, 0, 1, 9, 'hBEEF));
    tbl.push_back(V(1, 1, 'h40, 1, 1, 9, 'hBEEF, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 1, 0, 9, 0, B_RD, 0, 0, 0, 9, 0));
    tbl.push_back(V(1, 0, 0, 1, 0, 9, 0, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 1, 0, 9, 0, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 1, 0, 9, 0, B_IDLE, 0, 0, 1, 0, 'hBEEF));
    tbl.push_back(V(1, 0, 0, 1, 0, 9, 0, B_IDLE, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, B_IDLE, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].iv);
      ok = (obs() === {tbl[i].cs, tbl[i].oe, tbl[i].we, tbl[i].grant, tbl[i].rdv, tbl[i].ack});
      if (!tbl[i].cs) ok = ok && (bus.Mem_Addr === tbl[i].addr);
      if (tbl[i].rdv) ok = ok && (bus.Disp_RdData === tbl[i].data);
      else if (tbl[i].ack && tbl[i].we) ok = ok && (bus.Gfx_RdData === tbl[i].data);
      else if (tbl[i].ack) ok = ok && (bus.Mem_WrData === tbl[i].data);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d got cs,oe,we,grant,rdv,ack=%b addr=%h dd=%h gd=%h wd=%h want %b%b%b%b%b%b addr=%h data=%h",
                 i, obs(), bus.Mem_Addr, bus.Disp_RdData, bus.Gfx_RdData, bus.Mem_WrData,
                 tbl[i].cs, tbl[i].oe, tbl[i].we, tbl[i].grant, tbl[i].rdv, tbl[i].ack,
                 tbl[i].addr, tbl[i].data);
      end
    end

    // ---- reset while a display read is in flight: its data never returns ----
    step(mk_in(1, 0, 1, 3, 0, 0, 0, 0));
    check_bits("midrst_grant", obs(), 6'b001100);
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0));
    check_bits("midrst_reset", obs(), 6'b111000);
    for (int k = 0; k < 4; k++) begin
      step(mk_in(1, 0, 0, 0, 0, 0, 0, 0));
      check_bits("midrst_no_rdv", obs(), 6'b111000);
    end

    // ---- gfx write while video is active ----
`ifdef LCD_FB_BLANK_ONLY_WRITE_EN
    for (int k = 0; k < 4; k++) begin
      step(mk_in(1, 1, 0, 0, 1, 1, 'h77, 'h55AA));
      check_bits("blank_hold", obs(), 6'b111000);
    end
    step(mk_in(1, 0, 0, 0, 1, 1, 'h77, 'h55AA));
    check_bits("blank_wr", obs(), 6'b010001);
`else
    step(mk_in(1, 1, 0, 0, 1, 1, 'h77, 'h55AA));
    check_bits("active_wr", obs(), 6'b010001);
`endif
    step(mk_in(1, 1, 1, 'h10, 1, 1, 'h77, 'h55AA));
    check_bits("wr_turn", obs(), 6'b111000);
    step(mk_in(1, 1, 0, 0, 0, 0, 0, 0));
    check_bits("wr_after", obs(), 6'b111000);

    // ---- random traffic against the model ----
    g_act = 0; g_we = 0; g_drop = 0; g_addr = 0; g_wd = 0;
    for (int n = 0; n < 3000; n++) begin
      iv = '0;
      iv.rst_n   = ($urandom_range(0, 199) != 0);
      iv.blank_l = 1'($urandom_range(0, 1));
      iv.dreq    = ($urandom_range(0, 9) < 6);
      iv.daddr   = AW'($urandom_range(0, 63));
      if (!iv.rst_n) begin
        g_act = 0; g_drop = 0;
      end else if (g_drop) begin
        g_act = 0; g_drop = 0;
      end else if (g_act && bus.Gfx_Ack === 1'b1) begin
        g_drop = 1;
      end else if (!g_act && $urandom_range(0, 3) == 0) begin
        g_act  = 1;
        g_we   = 1'($urandom_range(0, 1));
        g_addr = $urandom_range(0, 63);
        g_wd   = int'($urandom_range(0, 65535));
      end
      iv.greq  = g_act;
      iv.gwe   = g_we;
      iv.gaddr = AW'(g_addr);
      iv.gwd   = DW'(g_wd);
      step(iv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
